// File: rtl/tx_sched_pkg.sv
// ---------------------------------------------------------------------------
// tx_sched_pkg
// Shared definitions for the UART transmit scheduler:
//   sched_state_e    : transmit handshake FSM states
//   TAG_W            : width of the source tag placed in the message MSBs
//                      when TX_SCHEDULER_TAG_EN is defined
//   LOW_TIMEOUT_DEF  : default wait for tx_ready to fall after a send
// ---------------------------------------------------------------------------
package tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_LOW  = 2'd2,
    ST_WAIT_HIGH = 2'd3
  } sched_state_e;

  localparam int TAG_W           = 2;
  localparam int LOW_TIMEOUT_DEF = 8;

endpackage : tx_sched_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin winner selection. The search starts at ptr_i and
// wraps modulo N; the first requesting index found wins.
// Ports:
//   req_i   [N-1:0] : request vector
//   ptr_i   [1:0]   : first index to consider (must be < N)
//   gnt_o   [N-1:0] : one-hot grant (all zero when nothing requests)
//   idx_o   [1:0]   : binary index of the winner
//   valid_o         : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
#(
  parameter int N = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [1:0]   ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [1:0]   idx_o,
  output logic         valid_o
);

  logic found;
  int   cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = 2'(cand);
      end
    end
  end

  assign valid_o = found;

endmodule : rr_arbiter

// File: rtl/tx_scheduler.sv
// ---------------------------------------------------------------------------
// tx_scheduler
// Shares one UART transmitter between NUM_REQ message sources. Each source
// has a single-entry hold register; a round-robin arbiter picks the next
// pending source whenever the transmitter is idle, and a four-state FSM
// (IDLE -> SEND -> WAIT_LOW -> WAIT_HIGH) paces the handshake so a new send
// is only issued after tx_ready has dropped (or timed out) and come back.
//
// Build option: define TX_SCHEDULER_TAG_EN to replace the top TAG_W bits of
// tx_message with the winning source index.
//
// Ports:
//   clock, reset  : clock and synchronous active-high reset
//   req_isNew     : per-source one-cycle "message offered" pulse
//   req_message   : source i payload at [i*MSG_W +: MSG_W]
//   req_pending   : source i hold register full
//   tx_ready      : transmitter idle
//   tx_isNew      : one-cycle send strobe
//   tx_message    : message for the transmitter, held until the next grant
//   grant_id      : index of the source last sent
//   overflow      : sticky per-source "pulse arrived while hold full"
//   drop_count    : saturating count of dropped pulses over all sources
// ---------------------------------------------------------------------------
module tx_scheduler
  import tx_sched_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int MSG_W       = 20,
  parameter int LOW_TIMEOUT = LOW_TIMEOUT_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_isNew,
  input  logic [NUM_REQ*MSG_W-1:0] req_message,
  output logic [NUM_REQ-1:0]       req_pending,
  input  logic                     tx_ready,
  output logic                     tx_isNew,
  output logic [MSG_W-1:0]         tx_message,
  output logic [1:0]               grant_id,
  output logic [NUM_REQ-1:0]       overflow,
  output logic [7:0]               drop_count
);

  localparam int CNT_W = $clog2(LOW_TIMEOUT + 1);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [1:0]       gid_q, gid_d;
  logic [7:0]       drop_q, drop_d;
  logic [8:0]       drop_sum;

  logic [NUM_REQ-1:0] pend_vec;
  logic [NUM_REQ-1:0] ovf_vec;
  logic [NUM_REQ-1:0] drop_vec;
  logic [MSG_W-1:0]   hold_vec [NUM_REQ];

  logic [1:0]         ptr;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [1:0]         arb_idx;
  logic               arb_valid;
  logic               grant_fire;
  logic [MSG_W-1:0]   win_msg;

  // Search begins one past the last grant; reset value of gid_q makes
  // source 0 the first candidate.
  assign ptr = (gid_q == 2'(NUM_REQ - 1)) ? 2'd0 : gid_q + 2'd1;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i   (pend_vec),
    .ptr_i   (ptr),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign grant_fire = (state_q == ST_IDLE) && tx_ready && arb_valid;

  // Per-source hold registers. A source being granted this cycle is
  // treated as empty, so a pulse coinciding with its grant refills it.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_src
      logic [MSG_W-1:0] hold_q;
      logic             pend_q;
      logic             ovf_q;
      logic             granted;
      logic             accept;
      logic             drop;

      assign granted = grant_fire & arb_gnt[gi];
      assign accept  = req_isNew[gi] & (~pend_q | granted);
      assign drop    = req_isNew[gi] & pend_q & ~granted;

      always_ff @(posedge clock) begin
        if (reset) begin
          hold_q <= '0;
          pend_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else begin
          if (accept) begin
            hold_q <= req_message[gi*MSG_W +: MSG_W];
            pend_q <= 1'b1;
          end else if (granted) begin
            pend_q <= 1'b0;
          end
          if (drop) begin
            ovf_q <= 1'b1;
          end
        end
      end

      assign hold_vec[gi] = hold_q;
      assign pend_vec[gi] = pend_q;
      assign ovf_vec[gi]  = ovf_q;
      assign drop_vec[gi] = drop;
    end
  endgenerate

  always_comb begin
    win_msg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        win_msg = hold_vec[i];
      end
    end
  end

  // Several sources can drop in the same cycle; add them all, then clamp.
  always_comb begin
    drop_sum = {1'b0, drop_q};
    for (int i = 0; i < NUM_REQ; i++) begin
      drop_sum = drop_sum + {8'd0, drop_vec[i]};
    end
    drop_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    msg_d   = msg_q;
    gid_d   = gid_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_fire) begin
          state_d = ST_SEND;
          gid_d   = arb_idx;
          msg_d   = win_msg;
`ifdef TX_SCHEDULER_TAG_EN
          msg_d[MSG_W-1 -: TAG_W] = arb_idx;
`endif
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT_LOW;
        cnt_d   = '0;
      end
      ST_WAIT_LOW: begin
        // A transmitter that never drops tx_ready must not stall us forever.
        if (!tx_ready || (cnt_q == CNT_W'(LOW_TIMEOUT - 1))) begin
          state_d = ST_WAIT_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (tx_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      msg_q   <= '0;
      gid_q   <= 2'(NUM_REQ - 1);
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      msg_q   <= msg_d;
      gid_q   <= gid_d;
      drop_q  <= drop_d;
    end
  end

  assign tx_isNew    = (state_q == ST_SEND);
  assign tx_message  = msg_q;
  assign grant_id    = gid_q;
  assign req_pending = pend_vec;
  assign overflow    = ovf_vec;
  assign drop_count  = drop_q;

endmodule : tx_scheduler
